// File: rtl/xpmwrap_sdpram_arbiter_if.sv
// ---------------------------------------------------------------------------
// xpmwrap_sdpram_arbiter_if
//
// Bundles every non-clock/reset signal of xpmwrap_sdpram_arbiter.
//   slave  : the arbiter's view (takes requests, drives the RAM ports)
//   master : the environment's view (issues requests, models the RAM)
//
// Groups:
//   wr0_* / wr1_*  write requesters (valid/ready, addr, data)
//   rd_req_*       read request (valid/ready, addr)
//   rd_rsp_*       read response (valid/ready, data)
//   mem_*          simple-dual-port RAM, port A write / port B read
// ---------------------------------------------------------------------------
interface xpmwrap_sdpram_arbiter_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  wr0_valid;
  logic                  wr0_ready;
  logic [ADDR_WIDTH-1:0] wr0_addr;
  logic [DATA_WIDTH-1:0] wr0_data;

  logic                  wr1_valid;
  logic                  wr1_ready;
  logic [ADDR_WIDTH-1:0] wr1_addr;
  logic [DATA_WIDTH-1:0] wr1_data;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_req_addr;

  logic                  rd_rsp_valid;
  logic                  rd_rsp_ready;
  logic [DATA_WIDTH-1:0] rd_rsp_data;

  logic                  mem_ena;
  logic                  mem_wea;
  logic [ADDR_WIDTH-1:0] mem_addra;
  logic [DATA_WIDTH-1:0] mem_dina;
  logic                  mem_enb;
  logic                  mem_regceb;
  logic [ADDR_WIDTH-1:0] mem_addrb;
  logic [DATA_WIDTH-1:0] mem_doutb;

  modport slave (
    input  wr0_valid, wr0_addr, wr0_data,
    input  wr1_valid, wr1_addr, wr1_data,
    input  rd_req_valid, rd_req_addr,
    input  rd_rsp_ready,
    input  mem_doutb,
    output wr0_ready, wr1_ready,
    output rd_req_ready,
    output rd_rsp_valid, rd_rsp_data,
    output mem_ena, mem_wea, mem_addra, mem_dina,
    output mem_enb, mem_regceb, mem_addrb
  );

  modport master (
    output wr0_valid, wr0_addr, wr0_data,
    output wr1_valid, wr1_addr, wr1_data,
    output rd_req_valid, rd_req_addr,
    output rd_rsp_ready,
    output mem_doutb,
    input  wr0_ready, wr1_ready,
    input  rd_req_ready,
    input  rd_rsp_valid, rd_rsp_data,
    input  mem_ena, mem_wea, mem_addra, mem_dina,
    input  mem_enb, mem_regceb, mem_addrb
  );
endinterface

// File: rtl/xpmwrap_sdpram_arbiter.sv
// ---------------------------------------------------------------------------
// xpmwrap_sdpram_arbiter
//
// Shares one simple-dual-port RAM (write port A, read port B, 2-cycle read
// latency, common clock) between two write requesters and one read
// requester.
//   - Writes: round-robin between wr0 and wr1, one grant per cycle, issued
//     to port A one cycle after the handshake.
//   - Reads: accepted while (inflight + buffered) < RSP_DEPTH, issued to
//     port B one cycle after accept, captured 3 cycles after accept into an
//     in-order response FIFO with a registered head, so the consumer may
//     stall without losing data.
//
// Ports:
//   clk    clock (also the RAM clock)
//   rst_n  asynchronous active-low reset; deassertion is synchronised here
//   bus    xpmwrap_sdpram_arbiter_if.slave (requests, response, RAM ports)
//
// Parameters: ADDR_WIDTH, DATA_WIDTH, RSP_DEPTH (power of 2, >= 2).
//
// Build option: XPMWRAP_ARB_COLLISION_STALL_EN
//   defined   -> a read whose address equals the address of the write
//                granted in the same cycle is held off for that cycle.
//   undefined -> no stall; the RAM's write_first behaviour decides.
// ---------------------------------------------------------------------------
module xpmwrap_sdpram_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  xpmwrap_sdpram_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // inflight (max 3) + count (max RSP_DEPTH) never overflows this width
  localparam int SUM_W = CNT_W + 2;
  localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(RSP_DEPTH);

  // -------------------------------------------------------------------------
  // Reset: assert asynchronously, release on a clock edge. While run is low
  // every handshake is blocked and all state is held at zero.
  // -------------------------------------------------------------------------
  logic [1:0] rst_sync_reg;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
    end
  end

  assign run = rst_sync_reg[1];

  // -------------------------------------------------------------------------
  // Write arbiter
  // ptr_reg = 0 favours wr0, 1 favours wr1. It flips to the side that was
  // not granted after every grant, and holds while nobody asks.
  // -------------------------------------------------------------------------
  logic                  ptr_reg, ptr_next;
  logic                  grant0, grant1, wr_fire;
  logic [ADDR_WIDTH-1:0] wr_addr_sel;
  logic [DATA_WIDTH-1:0] wr_data_sel;

  always_comb begin
    grant0      = run & bus.wr0_valid & (~bus.wr1_valid | ~ptr_reg);
    grant1      = run & bus.wr1_valid & (~bus.wr0_valid |  ptr_reg);
    wr_fire     = grant0 | grant1;
    wr_addr_sel = grant1 ? bus.wr1_addr : bus.wr0_addr;
    wr_data_sel = grant1 ? bus.wr1_data : bus.wr0_data;

    ptr_next = ptr_reg;
    if (!run) begin
      ptr_next = 1'b0;
    end else if (grant0) begin
      ptr_next = 1'b1;
    end else if (grant1) begin
      ptr_next = 1'b0;
    end
  end

  assign bus.wr0_ready = grant0;
  assign bus.wr1_ready = grant1;

  // -------------------------------------------------------------------------
  // Port A issue: one cycle after the handshake
  // -------------------------------------------------------------------------
  logic                  mem_ena_reg, mem_ena_next;
  logic [ADDR_WIDTH-1:0] mem_addra_reg, mem_addra_next;
  logic [DATA_WIDTH-1:0] mem_dina_reg, mem_dina_next;

  always_comb begin
    mem_ena_next   = 1'b0;
    mem_addra_next = mem_addra_reg;
    mem_dina_next  = mem_dina_reg;
    if (!run) begin
      mem_addra_next = '0;
      mem_dina_next  = '0;
    end else if (wr_fire) begin
      mem_ena_next   = 1'b1;
      mem_addra_next = wr_addr_sel;
      mem_dina_next  = wr_data_sel;
    end
  end

  assign bus.mem_ena   = mem_ena_reg;
  assign bus.mem_wea   = mem_ena_reg;
  assign bus.mem_addra = mem_addra_reg;
  assign bus.mem_dina  = mem_dina_reg;

  // -------------------------------------------------------------------------
  // Read accept
  // Credit is taken from registered inflight/count only: a pop in the
  // current cycle frees its slot for the next cycle, which keeps
  // rd_req_ready independent of rd_rsp_ready.
  // -------------------------------------------------------------------------
  logic [1:0]       inflight_reg, inflight_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [SUM_W-1:0] credit_used;
  logic             rd_block;
  logic             rd_ready;
  logic             rd_fire;

  assign credit_used = SUM_W'(inflight_reg) + SUM_W'(count_reg);

`ifdef XPMWRAP_ARB_COLLISION_STALL_EN
  // Hold the read one cycle so its port B access lands after the write
  // has completed on port A.
  assign rd_block = wr_fire && (wr_addr_sel == bus.rd_req_addr);
`else
  assign rd_block = 1'b0;
`endif

  assign rd_ready         = run & (credit_used < DEPTH_LIM) & ~rd_block;
  assign rd_fire          = rd_ready & bus.rd_req_valid;
  assign bus.rd_req_ready = rd_ready;

  // -------------------------------------------------------------------------
  // Port B issue and data tagging
  // vld_reg[0] coincides with mem_enb, vld_reg[2] with valid mem_doutb.
  // -------------------------------------------------------------------------
  logic                  mem_enb_reg, mem_enb_next;
  logic [ADDR_WIDTH-1:0] mem_addrb_reg, mem_addrb_next;
  logic [2:0]            vld_reg, vld_next;
  logic                  capture;

  always_comb begin
    mem_enb_next   = 1'b0;
    mem_addrb_next = mem_addrb_reg;
    if (!run) begin
      mem_addrb_next = '0;
    end else if (rd_fire) begin
      mem_enb_next   = 1'b1;
      mem_addrb_next = bus.rd_req_addr;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_vld
    if (gi == 0) begin : g_head
      assign vld_next[gi] = run & rd_fire;
    end else begin : g_tail
      assign vld_next[gi] = run & vld_reg[gi-1];
    end
  end

  assign capture        = vld_reg[2];
  assign bus.mem_enb    = mem_enb_reg;
  assign bus.mem_addrb  = mem_addrb_reg;
  assign bus.mem_regceb = 1'b1;

  // -------------------------------------------------------------------------
  // Response FIFO
  // Entries live in rsp_mem; the head is also held in rd_rsp_data_reg so
  // the output is a register. Every capture is written to rsp_mem, so
  // rsp_mem[rd_ptr+1] is always the next head once there are 2+ entries.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rsp_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_inc;
  logic [DATA_WIDTH-1:0] rd_rsp_data_reg, rd_rsp_data_next;
  logic                  rsp_valid;
  logic                  pop;

  assign rsp_valid  = (count_reg != '0);
  assign pop        = rsp_valid & bus.rd_rsp_ready;
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (capture) begin
      rsp_mem[wr_ptr_reg] <= bus.mem_doutb;
    end
  end

  always_comb begin
    inflight_next    = inflight_reg + {1'b0, rd_fire} - {1'b0, capture};
    count_next       = count_reg + CNT_W'(capture) - CNT_W'(pop);
    wr_ptr_next      = wr_ptr_reg + PTR_W'(capture);
    rd_ptr_next      = rd_ptr_reg + PTR_W'(pop);
    rd_rsp_data_next = rd_rsp_data_reg;

    if (pop) begin
      if (count_reg == CNT_W'(1)) begin
        // Last entry leaves; a same-cycle capture becomes the new head.
        if (capture) begin
          rd_rsp_data_next = bus.mem_doutb;
        end
      end else begin
        rd_rsp_data_next = rsp_mem[rd_ptr_inc];
      end
    end else if (!rsp_valid && capture) begin
      rd_rsp_data_next = bus.mem_doutb;
    end

    if (!run) begin
      inflight_next    = '0;
      count_next       = '0;
      wr_ptr_next      = '0;
      rd_ptr_next      = '0;
      rd_rsp_data_next = '0;
    end
  end

  assign bus.rd_rsp_valid = rsp_valid;
  assign bus.rd_rsp_data  = rd_rsp_data_reg;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg         <= 1'b0;
      mem_ena_reg     <= 1'b0;
      mem_addra_reg   <= '0;
      mem_dina_reg    <= '0;
      mem_enb_reg     <= 1'b0;
      mem_addrb_reg   <= '0;
      vld_reg         <= '0;
      inflight_reg    <= '0;
      count_reg       <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      rd_rsp_data_reg <= '0;
    end else begin
      ptr_reg         <= ptr_next;
      mem_ena_reg     <= mem_ena_next;
      mem_addra_reg   <= mem_addra_next;
      mem_dina_reg    <= mem_dina_next;
      mem_enb_reg     <= mem_enb_next;
      mem_addrb_reg   <= mem_addrb_next;
      vld_reg         <= vld_next;
      inflight_reg    <= inflight_next;
      count_reg       <= count_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
      rd_rsp_data_reg <= rd_rsp_data_next;
    end
  end

endmodule
